vga_timing_gen: RTL and testbench

Parametrised video timing generator. Produces horizontal/vertical beam counters, sync pulses, display-enable, line/frame strobes and a frame counter for the TinyVGA PMOD output path. Generalises the fixed 640x480 sync generator:
- All porch, sync and display sizes are parameters, as are the sync polarities.
- A pixel clock enable allows divided pixel rates.
- Syncs and display-enable are cycle-coherent with the counters.
- A configurable delay line aligns sync/enable with a pipelined pixel datapath.

---
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//    Parametrised video timing generator for the TinyVGA PMOD path.
//    Produces beam counters, sync pulses, display enable, line/frame
//    strobes, a frame counter and a delayed copy of sync/enable that
//    lines up with a pipelined pixel datapath.
//
// Ports
//    clk           in   pixel-domain clock
//    reset         in   synchronous, active-high
//    pix_en        in   advance enable; everything steps only when high
//    hpos, vpos    out  beam position (POS_W bits)
//    hsync, vsync  out  sync levels, asserted level set by *_SYNC_POL
//    display_on    out  position lies inside the visible area
//    line_start    out  one-clk pulse on the step that lands on hpos=0
//    frame_start   out  one-clk pulse on the step that lands on (0,0)
//    frame_count   out  frames started since reset, first frame = 0
//    hsync_d, vsync_d, display_on_d
//                  out  sync/enable delayed by PIPE_DELAY pix_en steps
//
// state | meaning
// ------+--------------------------------------------------------------
// (none)  pure counter datapath; reset parks the beam at (H_MAX,V_MAX)
//         so the first step lands on (0,0) and starts frame 0.

module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_BOTTOM   = 10,
   parameter int V_SYNC     = 2,
   parameter int V_TOP      = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int POS_W      = 10,
   parameter int FRAME_W    = 12,
   parameter int PIPE_DELAY = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   output logic [POS_W-1:0]   hpos,
   output logic [POS_W-1:0]   vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count,
   output logic               hsync_d,
   output logic               vsync_d,
   output logic               display_on_d
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

   localparam logic [POS_W-1:0] H_MAX    = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_MAX    = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_DISP   = POS_W'(H_DISPLAY);
   localparam logic [POS_W-1:0] V_DISP   = POS_W'(V_DISPLAY);
   localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
   localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_BOTTOM);
   localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

   localparam logic HS_ON = (H_SYNC_POL != 0);
   localparam logic VS_ON = (V_SYNC_POL != 0);

   logic [POS_W-1:0] h_nxt;
   logic [POS_W-1:0] v_nxt;
   logic             h_wrap;
   logic             f_wrap;
   logic             hs_nxt;
   logic             vs_nxt;
   logic             de_nxt;

   // Sync and enable are decoded from the next position and registered
   // alongside it, so they always describe the position on hpos/vpos.
   always_comb begin
      h_wrap = (hpos == H_MAX);
      f_wrap = h_wrap && (vpos == V_MAX);
      h_nxt  = h_wrap ? '0 : hpos + POS_W'(1);
      v_nxt  = vpos;
      if (h_wrap) begin
         v_nxt = (vpos == V_MAX) ? '0 : vpos + POS_W'(1);
      end
      hs_nxt = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? HS_ON : ~HS_ON;
      vs_nxt = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? VS_ON : ~VS_ON;
      de_nxt = (h_nxt < H_DISP) && (v_nxt < V_DISP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hpos        <= H_MAX;
         vpos        <= V_MAX;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '1;
      end else if (pix_en) begin
         hpos        <= h_nxt;
         vpos        <= v_nxt;
         hsync       <= hs_nxt;
         vsync       <= vs_nxt;
         display_on  <= de_nxt;
         line_start  <= h_wrap;
         frame_start <= f_wrap;
         if (f_wrap) begin
            frame_count <= frame_count + FRAME_W'(1);
         end
      end else begin
         // position held: strobes must not repeat
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

   generate
      if (PIPE_DELAY == 0) begin : g_no_delay
         assign hsync_d      = hsync;
         assign vsync_d      = vsync;
         assign display_on_d = display_on;
      end else begin : g_delay
         localparam logic [2:0] STAGE_RST = {~HS_ON, ~VS_ON, 1'b0};

         logic [2:0] stage [PIPE_DELAY];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DELAY; i++) begin
                  stage[i] <= STAGE_RST;
               end
            end else if (pix_en) begin
               stage[0] <= {hsync, vsync, display_on};
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign hsync_d      = stage[PIPE_DELAY-1][2];
         assign vsync_d      = stage[PIPE_DELAY-1][1];
         assign display_on_d = stage[PIPE_DELAY-1][0];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//    Instance a: default 640x480 timing, no delay line, first line only.
//    Instance b: shrunken 16x12 timing, active-high hsync, 3-stage delay,
//    3-bit frame counter so full frames and rollover fit in a short run.
//    b timing: hsync on hpos 10..12, vsync on vpos 8..9, visible 8x6.

module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pix_en = 1'b0;

   always #5 clk = ~clk;

   logic [9:0]  a_hpos, a_vpos;
   logic        a_hs, a_vs, a_de, a_ls, a_fs, a_hsd, a_vsd, a_ded;
   logic [11:0] a_fc;

   logic [4:0]  b_hpos, b_vpos;
   logic        b_hs, b_vs, b_de, b_ls, b_fs, b_hsd, b_vsd, b_ded;
   logic [2:0]  b_fc;

   vga_timing_gen u_a (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hs), .vsync(a_vs),
      .display_on(a_de), .line_start(a_ls), .frame_start(a_fs),
      .frame_count(a_fc), .hsync_d(a_hsd), .vsync_d(a_vsd),
      .display_on_d(a_ded)
   );

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
      .H_SYNC_POL(1), .V_SYNC_POL(0),
      .POS_W(5), .FRAME_W(3), .PIPE_DELAY(3)
   ) u_b (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
      .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
      .frame_count(b_fc), .hsync_d(b_hsd), .vsync_d(b_vsd),
      .display_on_d(b_ded)
   );

   int checks = 0;
   int errors = 0;
   int prints = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance a checkpoint table ----------------
   typedef struct {
      int cyc;
      int hpos;
      int vpos;
      int hs;
      int de;
      int ls;
      int fs;
   } vec_t;

   vec_t vecs [9];

   // ---------------- instance b reference ----------------
   typedef struct {
      int h, v, hs, vs, de, ls, fs, fc, hsd, vsd, ded;
   } bexp_t;

   function automatic int b_hs_of(int s);
      int h = s % 16;
      return (h >= 10 && h <= 12) ? 1 : 0;
   endfunction

   function automatic int b_vs_of(int s);
      int v = (s / 16) % 12;
      return (v >= 8 && v <= 9) ? 0 : 1;
   endfunction

   function automatic int b_de_of(int s);
      int h = s % 16;
      int v = (s / 16) % 12;
      return (h < 8 && v < 6) ? 1 : 0;
   endfunction

   // s = steps since the step that produced (0,0); stepped = a step
   // happened on the edge just before this sample.
   function automatic bexp_t b_model(int s, bit stepped);
      bexp_t e;
      e.h   = s % 16;
      e.v   = (s / 16) % 12;
      e.hs  = b_hs_of(s);
      e.vs  = b_vs_of(s);
      e.de  = b_de_of(s);
      e.ls  = (stepped && e.h == 0) ? 1 : 0;
      e.fs  = (stepped && e.h == 0 && e.v == 0) ? 1 : 0;
      e.fc  = (s / 192) % 8;
      if (s < 3) begin
         e.hsd = 0; e.vsd = 1; e.ded = 0;
      end else begin
         e.hsd = b_hs_of(s - 3);
         e.vsd = b_vs_of(s - 3);
         e.ded = b_de_of(s - 3);
      end
      return e;
   endfunction

   task automatic chk_b(input string tag, input int s, input bit stepped);
      bexp_t e;
      bit bad;
      e = b_model(s, stepped);
      bad = (int'(b_hpos) != e.h) || (int'(b_vpos) != e.v) ||
            (int'(b_hs) != e.hs) || (int'(b_vs) != e.vs) ||
            (int'(b_de) != e.de) || (int'(b_ls) != e.ls) ||
            (int'(b_fs) != e.fs) || (int'(b_fc) != e.fc) ||
            (int'(b_hsd) != e.hsd) || (int'(b_vsd) != e.vsd) ||
            (int'(b_ded) != e.ded);
      checks++;
      if (bad) begin
         errors++;
         if (prints < 20) begin
            prints++;
            $display("FAIL %s step %0d: got h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d d=%0d%0d%0d, expected h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d d=%0d%0d%0d",
                     tag, s, b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_fc,
                     b_hsd, b_vsd, b_ded, e.h, e.v, e.hs, e.vs, e.de, e.ls,
                     e.fs, e.fc, e.hsd, e.vsd, e.ded);
         end
      end
   endtask

   int cyc;
   int ls_cnt;
   int s;
   int vs_low;
   int fs_cnt;
   int first_ded;
   int first_hsd;
   int ls_first;
   int ls_second;
   bit stepped;

   initial begin
      vecs[0] = '{cyc:   0, hpos:   0, vpos: 0, hs: 1, de: 1, ls: 1, fs: 1};
      vecs[1] = '{cyc: 639, hpos: 639, vpos: 0, hs: 1, de: 1, ls: 0, fs: 0};
      vecs[2] = '{cyc: 640, hpos: 640, vpos: 0, hs: 1, de: 0, ls: 0, fs: 0};
      vecs[3] = '{cyc: 655, hpos: 655, vpos: 0, hs: 1, de: 0, ls: 0, fs: 0};
      vecs[4] = '{cyc: 656, hpos: 656, vpos: 0, hs: 0, de: 0, ls: 0, fs: 0};
      vecs[5] = '{cyc: 751, hpos: 751, vpos: 0, hs: 0, de: 0, ls: 0, fs: 0};
      vecs[6] = '{cyc: 752, hpos: 752, vpos: 0, hs: 1, de: 0, ls: 0, fs: 0};
      vecs[7] = '{cyc: 799, hpos: 799, vpos: 0, hs: 1, de: 0, ls: 0, fs: 0};
      vecs[8] = '{cyc: 800, hpos:   0, vpos: 1, hs: 1, de: 1, ls: 1, fs: 0};

      // reset held 3 cycles with pix_en high
      reset = 1'b1;
      pix_en = 1'b1;
      repeat (3) tick();
      chk("a_rst_hpos", a_hpos, 799);
      chk("a_rst_vpos", a_vpos, 524);
      chk("a_rst_syncs_de", {a_hs, a_vs, a_de}, 3'b110);
      chk("a_rst_strobes", {a_ls, a_fs}, 0);
      chk("a_rst_fc", a_fc, 4095);
      chk("a_rst_delayed", {a_hsd, a_vsd, a_ded}, 3'b110);
      chk("b_rst_pos", {b_hpos, b_vpos}, {5'd15, 5'd11});
      chk("b_rst_syncs_de", {b_hs, b_vs, b_de}, 3'b010);
      chk("b_rst_fc", b_fc, 7);
      chk("b_rst_delayed", {b_hsd, b_vsd, b_ded}, 3'b010);

      // instance a: first line checkpoints
      reset = 1'b0;
      tick();
      cyc = 0;
      ls_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         while (cyc < vecs[i].cyc) begin
            tick();
            cyc++;
            if (a_ls && cyc < 800) ls_cnt++;
         end
         chk($sformatf("a_hpos@%0d", cyc), a_hpos, vecs[i].hpos);
         chk($sformatf("a_vpos@%0d", cyc), a_vpos, vecs[i].vpos);
         chk($sformatf("a_hsync@%0d", cyc), a_hs, vecs[i].hs);
         chk($sformatf("a_de@%0d", cyc), a_de, vecs[i].de);
         chk($sformatf("a_ls@%0d", cyc), a_ls, vecs[i].ls);
         chk($sformatf("a_fs@%0d", cyc), a_fs, vecs[i].fs);
         chk($sformatf("a_vsync@%0d", cyc), a_vs, 1);
         chk($sformatf("a_fc@%0d", cyc), a_fc, 0);
         chk($sformatf("a_delayed@%0d", cyc), {a_hsd, a_vsd, a_ded},
             {vecs[i].hs[0], 1'b1, vecs[i].de[0]});
      end
      chk("a_line_start_inside_line", ls_cnt, 0);

      // instance b: free run across 8 frames plus rollover
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      s = 0;
      chk_b("b_run", s, 1'b1);
      vs_low = (b_vs == 1'b0) ? 1 : 0;
      fs_cnt = b_fs ? 1 : 0;
      first_ded = -1;
      first_hsd = -1;
      for (int n = 1; n <= 1536; n++) begin
         tick();
         s++;
         chk_b("b_run", s, 1'b1);
         if (s < 192 && b_vs == 1'b0) vs_low++;
         if (b_fs) fs_cnt++;
         if (first_ded < 0 && b_ded) first_ded = s;
         if (first_hsd < 0 && b_hsd) first_hsd = s;
      end
      chk("b_vsync_clks_frame0", vs_low, 32);
      chk("b_frame_starts", fs_cnt, 9);
      chk("b_fc_rollover", b_fc, 0);
      chk("b_de_d_first_rise", first_ded, 3);
      chk("b_hsync_d_first_assert", first_hsd, 13);

      // pix_en toggling 1,0,1,0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pix_en = 1'b1;
      tick();
      s = 0;
      chk_b("b_toggle", s, 1'b1);
      ls_first = 0;
      ls_second = -1;
      for (int n = 1; n <= 420; n++) begin
         pix_en = (n % 2 == 0);
         stepped = pix_en;
         tick();
         if (stepped) s++;
         chk_b("b_toggle", s, stepped);
         if (ls_second < 0 && b_ls) ls_second = n;
      end
      chk("b_toggle_line_period", ls_second - ls_first, 32);

      // reset for one cycle mid-frame at (5,3)
      pix_en = 1'b1;
      for (int n = 0; n < 400 && (s % 192) != 53; n++) begin
         tick();
         s++;
      end
      chk("b_pre_reset_pos", {b_hpos, b_vpos}, {5'd5, 5'd3});
      reset = 1'b1;
      tick();
      chk("b_midreset_pos", {b_hpos, b_vpos}, {5'd15, 5'd11});
      chk("b_midreset_de_fs", {b_de, b_fs}, 0);
      reset = 1'b0;
      tick();
      chk("b_after_reset_pos", {b_hpos, b_vpos}, 0);
      chk("b_after_reset_fs_ls", {b_fs, b_ls}, 2'b11);
      chk("b_after_reset_fc", b_fc, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
